// File: rtl/rc6_pkg.sv
// rc6_pkg -- shared definitions for the iterative RC6 block cipher.
//   WORD_W      : RC6 word width (32)
//   ROUNDS_DEF  : default round count (20)
//   key_words() : expanded key table size, 2*R+4 words
//   state_t     : controller states
//   bswap32, rotl32, rotr32 : word helpers (rotations use the low 5 bits)
package rc6_pkg;

  localparam int WORD_W     = 32;
  localparam int ROUNDS_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int key_words(input int rounds);
    return 2 * rounds + 4;
  endfunction

  // RC6 words are little-endian; the external bus is big-endian by byte.
  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                                input logic [4:0]        n);
    logic [2*WORD_W-1:0] t;
    t = {x, x} << n;
    return t[2*WORD_W-1:WORD_W];
  endfunction

  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x,
                                                input logic [4:0]        n);
    logic [2*WORD_W-1:0] t;
    t = {x, x} >> n;
    return t[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/rc6_round.sv
// rc6_round -- one combinational RC6 round.
//   a,b,c,d          : current state words
//   s_lo, s_hi       : round keys S[2i], S[2i+1]
//   dec              : select inverse round (only with RC6_DECRYPT_EN)
//   a_nx..d_nx       : state words after the round (rotation included)
// Build option: RC6_DECRYPT_EN adds the inverse round and the dec input.
module rc6_round
  import rc6_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  input  logic [WORD_W-1:0] s_lo,
  input  logic [WORD_W-1:0] s_hi,
`ifdef RC6_DECRYPT_EN
  input  logic              dec,
`endif
  output logic [WORD_W-1:0] a_nx,
  output logic [WORD_W-1:0] b_nx,
  output logic [WORD_W-1:0] c_nx,
  output logic [WORD_W-1:0] d_nx
);

  // f(x) = (x * (2x + 1)) <<< lg(w)
  function automatic logic [WORD_W-1:0] mix(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] p;
    p = x * ((x << 1) + WORD_W'(1));
    return rotl32(p, 5'd5);
  endfunction

  logic [WORD_W-1:0] t_f, u_f;

  always_comb begin
    t_f  = mix(b);
    u_f  = mix(d);
    a_nx = b;
    b_nx = rotl32(c ^ u_f, t_f[4:0]) + s_hi;
    c_nx = d;
    d_nx = rotl32(a ^ t_f, u_f[4:0]) + s_lo;
`ifdef RC6_DECRYPT_EN
    // Inverse: undo the word rotation first, so t/u come from old A and old C.
    if (dec) begin
      t_f  = mix(a);
      u_f  = mix(c);
      a_nx = rotr32(d - s_lo, u_f[4:0]) ^ t_f;
      b_nx = a;
      c_nx = rotr32(b - s_hi, t_f[4:0]) ^ u_f;
      d_nx = c;
    end
`endif
  end

endmodule

// File: rtl/rc6_cipher_iter.sv
// rc6_cipher_iter -- iterative RC6 block cipher, one round per clock.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_exkey           : expanded key table, S[0] in the top 32 bits
//   i_key_ok          : key table valid; dropping it aborts a running block
//   i_valid/o_ready   : input block handshake (i_din, i_dec)
//   o_valid/i_ready   : result handshake (o_dout)
//   o_abort           : one-cycle pulse when a running block is dropped
// Build option: RC6_DECRYPT_EN enables decryption via i_dec; otherwise
// i_dec is ignored and every block is encrypted.
//
// state | meaning
// IDLE  | waiting for a block (o_ready when keys are valid)
// RUN   | one round per cycle, counter counts R..1
// DONE  | o_dout/o_valid held until i_ready
module rc6_cipher_iter
  import rc6_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [WORD_W*(2*ROUNDS+4)-1:0]      i_exkey,
  input  logic                                i_key_ok,
  input  logic                                i_valid,
  input  logic                                i_dec,
  input  logic [127:0]                        i_din,
  output logic                                o_ready,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [127:0]                        o_dout,
  output logic                                o_abort
);

  localparam int KEY_W = WORD_W * key_words(ROUNDS);
  localparam int CW    = $clog2(ROUNDS + 1);
  localparam int LAST  = 2 * ROUNDS + 2;

  state_t            state_q, state_d;
  logic [CW-1:0]     rnd_cnt;
  logic [WORD_W-1:0] a_q, b_q, c_q, d_q;
  logic [WORD_W-1:0] s_w0, s_w1, s_wa, s_wc, s_lo, s_hi;
  logic [WORD_W-1:0] in_a, in_b, in_c, in_d;
  logic [WORD_W-1:0] pre_a, pre_b, pre_c, pre_d;
  logic [WORD_W-1:0] rn_a, rn_b, rn_c, rn_d;
  logic [WORD_W-1:0] post_a, post_b, post_c, post_d;
  logic              accept, last_rnd;
  int                ri;
`ifdef RC6_DECRYPT_EN
  logic              dec_q;
`endif

  assign o_ready  = (state_q == IDLE) && i_key_ok;
  assign o_valid  = (state_q == DONE);
  assign accept   = i_valid && o_ready;
  assign last_rnd = (rnd_cnt == CW'(1));

  // Whitening keys sit at fixed table positions.
  assign s_w0 = i_exkey[KEY_W-1 -: WORD_W];
  assign s_w1 = i_exkey[KEY_W-1-WORD_W -: WORD_W];
  assign s_wa = i_exkey[KEY_W-1-WORD_W*LAST -: WORD_W];
  assign s_wc = i_exkey[KEY_W-1-WORD_W*(LAST+1) -: WORD_W];

  assign in_a = bswap32(i_din[127:96]);
  assign in_b = bswap32(i_din[95:64]);
  assign in_c = bswap32(i_din[63:32]);
  assign in_d = bswap32(i_din[31:0]);

  // Round index from the down-counter: enc walks 1..R, dec walks R..1.
  always_comb begin
    ri = ROUNDS + 1 - int'(rnd_cnt);
`ifdef RC6_DECRYPT_EN
    if (dec_q) ri = int'(rnd_cnt);
`endif
    s_lo = i_exkey[KEY_W-1-WORD_W*(2*ri) -: WORD_W];
    s_hi = i_exkey[KEY_W-1-WORD_W*(2*ri+1) -: WORD_W];
  end

  rc6_round u_round (
    .a    (a_q),
    .b    (b_q),
    .c    (c_q),
    .d    (d_q),
    .s_lo (s_lo),
    .s_hi (s_hi),
`ifdef RC6_DECRYPT_EN
    .dec  (dec_q),
`endif
    .a_nx (rn_a),
    .b_nx (rn_b),
    .c_nx (rn_c),
    .d_nx (rn_d)
  );

  always_comb begin
    pre_a  = in_a;
    pre_b  = in_b + s_w0;
    pre_c  = in_c;
    pre_d  = in_d + s_w1;
    post_a = rn_a + s_wa;
    post_b = rn_b;
    post_c = rn_c + s_wc;
    post_d = rn_d;
`ifdef RC6_DECRYPT_EN
    if (i_dec) begin
      pre_a = in_a - s_wa;
      pre_b = in_b;
      pre_c = in_c - s_wc;
      pre_d = in_d;
    end
    if (dec_q) begin
      post_a = rn_a;
      post_b = rn_b - s_w0;
      post_c = rn_c;
      post_d = rn_d - s_w1;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (!i_key_ok) state_d = IDLE;
               else if (last_rnd) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rnd_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      o_dout  <= '0;
      o_abort <= 1'b0;
`ifdef RC6_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      o_abort <= 1'b0;
      if (state_q == IDLE && accept) begin
        a_q     <= pre_a;
        b_q     <= pre_b;
        c_q     <= pre_c;
        d_q     <= pre_d;
        rnd_cnt <= CW'(ROUNDS);
`ifdef RC6_DECRYPT_EN
        dec_q   <= i_dec;
`endif
      end else if (state_q == RUN) begin
        if (!i_key_ok) begin
          // Keys changed under us: the partial block is meaningless.
          o_abort <= 1'b1;
          rnd_cnt <= '0;
        end else begin
          a_q     <= rn_a;
          b_q     <= rn_b;
          c_q     <= rn_c;
          d_q     <= rn_d;
          rnd_cnt <= rnd_cnt - CW'(1);
          if (last_rnd)
            o_dout <= {bswap32(post_a), bswap32(post_b),
                       bswap32(post_c), bswap32(post_d)};
        end
      end
    end
  end

endmodule

// File: tb/tb_rc6_cipher_iter.sv
module tb_rc6_cipher_iter;

  localparam int R  = 20;
  localparam int KW = 2 * R + 4;
  localparam logic [127:0] KEY2 = 128'h0123456789abcdef0112233445566778;
  localparam logic [127:0] PT2  = 128'h02132435465768798a9bacbdcedfe0f1;
  localparam logic [127:0] CT2  = 128'h524e192f4715c6231f51f6367ea43f18;
  localparam logic [127:0] CT0  = 128'h8fc3a53656b1f778c129df4e9848a41e;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [32*KW-1:0]   i_exkey;
  logic               i_key_ok, i_valid, i_dec, i_ready;
  logic [127:0]       i_din;
  logic               o_ready, o_valid, o_abort;
  logic [127:0]       o_dout;

  int errors = 0;
  int checks = 0;

  rc6_cipher_iter #(.ROUNDS(R)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_exkey  (i_exkey),
    .i_key_ok (i_key_ok),
    .i_valid  (i_valid),
    .i_dec    (i_dec),
    .i_din    (i_din),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_dout   (o_dout),
    .o_abort  (o_abort)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference RC6 key schedule (16-byte key, w=32).
  function automatic logic [32*KW-1:0] expand(input logic [127:0] key);
    logic [31:0] s [KW];
    logic [31:0] l [4];
    logic [31:0] a, b, ab;
    logic [32*KW-1:0] r;
    int i, j;
    for (int k = 0; k < 4; k++) l[k] = bsw(key[127-32*k -: 32]);
    s[0] = 32'hB7E15163;
    for (int k = 1; k < KW; k++) s[k] = s[k-1] + 32'h9E3779B9;
    a = '0; b = '0; i = 0; j = 0;
    for (int k = 0; k < 3 * KW; k++) begin
      s[i] = rol(s[i] + a + b, 5'd3);
      a    = s[i];
      ab   = a + b;
      l[j] = rol(l[j] + ab, ab[4:0]);
      b    = l[j];
      i = (i + 1) % KW;
      j = (j + 1) % 4;
    end
    for (int k = 0; k < KW; k++) r[32*KW-1-32*k -: 32] = s[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one block; return cycles from accepting edge to o_valid, and o_dout.
  task automatic run_block(input logic [127:0] din, input logic dec,
                           output int lat, output logic [127:0] dout);
    i_din = din; i_dec = dec; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 60) begin
      tick();
      lat++;
    end
    dout = o_dout;
  endtask

  task automatic release_done();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] dout;
    logic saw_valid;

    i_rst = 1'b1; i_key_ok = 1'b1; i_valid = 1'b0; i_dec = 1'b0;
    i_ready = 1'b0; i_din = '0; i_exkey = expand('0);
    repeat (3) tick();

    checks++; assert (o_valid === 1'b0) else begin errors++; $error("FAIL rst_valid got=%b want=0", o_valid); end
    checks++; assert (o_abort === 1'b0) else begin errors++; $error("FAIL rst_abort got=%b want=0", o_abort); end
    checks++; assert (o_dout === 128'h0) else begin errors++; $error("FAIL rst_dout got=%h want=0", o_dout); end

    i_rst = 1'b0;
    tick();
    checks++; assert (o_ready === 1'b1) else begin errors++; $error("FAIL idle_ready got=%b want=1", o_ready); end

    // Keys invalid: not ready, and i_valid is ignored.
    i_key_ok = 1'b0; #1;
    checks++; assert (o_ready === 1'b0) else begin errors++; $error("FAIL nokey_ready got=%b want=0", o_ready); end
    i_valid = 1'b1; i_din = PT2;
    repeat (2) tick();
    i_valid = 1'b0; i_key_ok = 1'b1;
    tick();
    checks++; assert (o_ready === 1'b1) else begin errors++; $error("FAIL nokey_ignored got=%b want=1", o_ready); end

    // Zero key, zero plaintext.
    run_block('0, 1'b0, lat, dout);
    checks++; assert (lat === R) else begin errors++; $error("FAIL lat0 got=%0d want=%0d", lat, R); end
    checks++; assert (dout === CT0) else begin errors++; $error("FAIL ct0 got=%h want=%h", dout, CT0); end

    // Backpressure: hold in DONE for 10 cycles while poking i_valid.
    for (int k = 0; k < 10; k++) begin
      i_valid = k[0];
      i_din   = {4{$urandom}};
      tick();
      checks++;
      assert (o_valid === 1'b1 && o_ready === 1'b0 && o_dout === CT0)
        else begin errors++; $error("FAIL hold%0d got v=%b r=%b d=%h want v=1 r=0 d=%h", k, o_valid, o_ready, o_dout, CT0); end
    end
    // i_valid high while leaving DONE must not start a block.
    i_valid = 1'b1; i_din = PT2;
    release_done();
    i_valid = 1'b0;
    checks++; assert (o_valid === 1'b0) else begin errors++; $error("FAIL rel_valid got=%b want=0", o_valid); end
    checks++; assert (o_ready === 1'b1) else begin errors++; $error("FAIL rel_noaccept got=%b want=1", o_ready); end

    // Standard test vector with a non-trivial key.
    i_exkey = expand(KEY2);
    run_block(PT2, 1'b0, lat, dout);
    checks++; assert (lat === R) else begin errors++; $error("FAIL lat2 got=%0d want=%0d", lat, R); end
    checks++; assert (dout === CT2) else begin errors++; $error("FAIL ct2 got=%h want=%h", dout, CT2); end
    release_done();

`ifdef RC6_DECRYPT_EN
    run_block(CT2, 1'b1, lat, dout);
    checks++; assert (lat === R) else begin errors++; $error("FAIL latdec got=%0d want=%0d", lat, R); end
    checks++; assert (dout === PT2) else begin errors++; $error("FAIL dec2 got=%h want=%h", dout, PT2); end
`else
    // Without decryption support i_dec must be ignored.
    run_block(PT2, 1'b1, lat, dout);
    checks++; assert (lat === R) else begin errors++; $error("FAIL latdec got=%0d want=%0d", lat, R); end
    checks++; assert (dout === CT2) else begin errors++; $error("FAIL decign got=%h want=%h", dout, CT2); end
`endif
    release_done();

    // Key drop at RUN cycle 7.
    i_exkey = expand('0);
    i_din = '0; i_dec = 1'b0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (6) tick();
    checks++; assert (o_ready === 1'b0) else begin errors++; $error("FAIL run_ready got=%b want=0", o_ready); end
    i_key_ok = 1'b0;
    tick();
    checks++; assert (o_abort === 1'b1) else begin errors++; $error("FAIL abort_pulse got=%b want=1", o_abort); end
    checks++; assert (o_valid === 1'b0) else begin errors++; $error("FAIL abort_valid got=%b want=0", o_valid); end
    i_key_ok = 1'b1; #1;
    checks++; assert (o_ready === 1'b1) else begin errors++; $error("FAIL abort_idle got=%b want=1", o_ready); end
    tick();
    checks++; assert (o_abort === 1'b0) else begin errors++; $error("FAIL abort_width got=%b want=0", o_abort); end
    saw_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (o_valid) saw_valid = 1'b1;
    end
    checks++; assert (saw_valid === 1'b0) else begin errors++; $error("FAIL abort_novalid got=%b want=0", saw_valid); end

    // Reset at RUN cycle 10, then a clean block.
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    i_rst = 1'b1; #1;
    checks++; assert (o_valid === 1'b0) else begin errors++; $error("FAIL mrst_valid got=%b want=0", o_valid); end
    checks++; assert (o_abort === 1'b0) else begin errors++; $error("FAIL mrst_abort got=%b want=0", o_abort); end
    checks++; assert (o_dout === 128'h0) else begin errors++; $error("FAIL mrst_dout got=%h want=0", o_dout); end
    repeat (2) tick();
    i_rst = 1'b0;
    tick();
    run_block('0, 1'b0, lat, dout);
    checks++; assert (lat === R) else begin errors++; $error("FAIL lat_post got=%0d want=%0d", lat, R); end
    checks++; assert (dout === CT0) else begin errors++; $error("FAIL ct_post got=%h want=%h", dout, CT0); end
    release_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rc6_cipher_iter.md
RC6_CIPHER_ITER -- requirements
Module: rc6_cipher_iter

Interface
REQ-001 SHALL have parameter ROUNDS, default 20: number of RC6 rounds; round-key bus width is 32*(2*ROUNDS+4).
REQ-002 SHALL have port i_clk, input, 1: clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_exkey, input, 32*(2*ROUNDS+4): expanded round keys; S[k] = i_exkey[32*(2*ROUNDS+4)-1-32k -: 32].
REQ-005 SHALL have port i_key_ok, input, 1: round keys valid and stable (from key-expansion stage).
REQ-006 SHALL have port i_valid, input, 1: input block valid.
REQ-007 SHALL have port i_dec, input, 1: 0 = encrypt, 1 = decrypt; sampled with i_din.
REQ-008 SHALL have port i_din, input, 128: input block; byte 0 in i_din[127:120].
REQ-009 SHALL have port o_ready, output, 1: block can be accepted.
REQ-010 SHALL have port o_valid, output, 1: o_dout holds a result.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts o_dout.
REQ-012 SHALL have port o_dout, output, 128: result block, same byte order as i_din.
REQ-013 SHALL have port o_abort, output, 1: one-cycle pulse when an operation is dropped.

Function
REQ-014 Words A,B,C,D SHALL be the byte-swapped (little-endian) 32-bit words i_din[127:96], [95:64], [63:32], [31:0]; o_dout SHALL be packed with the same swap.
REQ-015 States SHALL be IDLE, RUN, DONE; o_ready = (state==IDLE) & i_key_ok.
REQ-016 Transfer on i_valid & o_ready SHALL register pre-whitened state (enc: B+=S[0], D+=S[1]; dec: C-=S[2R+3], A-=S[2R+2]), latch mode, set round counter, and enter RUN.
REQ-017 RUN SHALL perform exactly one RC6 round per cycle, using rounds 1..R for enc and R..1 for dec; all arithmetic modulo 2^32, rotations by low 5 bits.
REQ-018 The last RUN cycle SHALL apply post-whitening (enc: A+=S[2R+2], C+=S[2R+3]; dec: D-=S[1], B-=S[0]) and register o_dout; o_valid SHALL rise exactly R cycles after the accepting edge.
REQ-019 DONE SHALL hold o_dout and o_valid stable until i_ready, then return to IDLE with o_valid low on the next edge; no new block is accepted in the same cycle.
REQ-020 If i_key_ok falls during RUN, the block SHALL return to IDLE, pulse o_abort for one cycle, and never assert o_valid for that block.
REQ-021 A fall of i_key_ok in DONE SHALL NOT disturb o_dout or o_valid.
REQ-022 i_valid while o_ready is low SHALL be ignored; i_din is not stored.

Reset
REQ-023 On i_rst: state IDLE, o_valid 0, o_abort 0, o_dout 0, round counter 0, state words 0; reset mid-operation discards the block with no o_abort pulse.

Configuration
REQ-024 With RC6_DECRYPT_EN defined, i_dec SHALL select decryption per REQ-016..018.
REQ-025 Without RC6_DECRYPT_EN, i_dec SHALL be ignored, all blocks SHALL be encrypted, and no inverse-round logic SHALL be synthesized.

Structure
REQ-026 Shared package rc6_pkg SHALL hold the word width (32), the default round count (20), the key-table size function 2*R+4, and the state-enum typedef.
REQ-027 One sub-module, rc6_round, SHALL compute a single forward (and, under RC6_DECRYPT_EN, inverse) round combinationally from A,B,C,D and S[2i],S[2i+1].

Verification
REQ-028 Zero key, i_din=0, enc -> o_dout=128'h8fc3a53656b1f778c129df4e9848a41e, o_valid high 20 cycles after accept.
REQ-029 Key 0123456789abcdef0112233445566778, i_din=128'h02132435465768798a9bacbdcedfe0f1, enc -> 128'h524e192f4715c6231f51f6367ea43f18.
REQ-030 With RC6_DECRYPT_EN: REQ-029 ciphertext, dec -> 128'h02132435465768798a9bacbdcedfe0f1.
REQ-031 i_ready held low 10 cycles in DONE -> o_dout and o_valid stable; o_ready 0 throughout; i_valid pulses ignored.
REQ-032 i_key_ok dropped at RUN cycle 7 -> o_abort one-cycle pulse, state IDLE, no o_valid.
REQ-033 i_rst asserted at RUN cycle 10 -> all outputs 0 immediately; next REQ-028 block yields correct result.
